// File: rtl/pipe_scoreboard.sv
// Register scoreboard and ID->EXE issue control for the RV64 in-order pipe.
// Optional SB_WB_BYPASS_EN masks a source hazard on the retiring write.
module pipe_scoreboard #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic              id_rs1_en,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs2_en,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_en,
    input  logic              exe_ready,
    input  logic              wb_rd_en,
    input  logic [4:0]        wb_rd,
    input  logic              flush,
    output logic              id_stall,
    output logic              id_issue,
    output logic              sb_err,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;

    logic [CNT_W-1:0] c1;
    logic [CNT_W-1:0] c2;
    logic [CNT_W-1:0] cd;
    logic [CNT_W-1:0] cw;
    logic             byp1;
    logic             byp2;
    logic             haz1;
    logic             haz2;
    logic             hazd;
    logic             wb_err;

    assign c1 = cnt[id_rs1];
    assign c2 = cnt[id_rs2];
    assign cd = cnt[id_rd];
    assign cw = cnt[wb_rd];

`ifdef SB_WB_BYPASS_EN
    // The last in-flight write retiring now reaches the reader via regfile write-through.
    assign byp1 = wb_rd_en && (wb_rd == id_rs1) && (c1 == CONE);
    assign byp2 = wb_rd_en && (wb_rd == id_rs2) && (c2 == CONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign haz1 = id_rs1_en && (id_rs1 != 5'd0) && (c1 != '0) && !byp1;
    assign haz2 = id_rs2_en && (id_rs2 != 5'd0) && (c2 != '0) && !byp2;
    assign hazd = id_rd_en && (id_rd != 5'd0) && (cd == CMAX);

    assign id_stall = !rst && id_valid && !flush
                      && (haz1 || haz2 || hazd || !exe_ready);
    assign id_issue = !rst && id_valid && !flush && !id_stall;

    assign wb_err = wb_rd_en && (wb_rd != 5'd0) && (cw == '0);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r != 0) begin
                inc[r] = id_issue && id_rd_en && (id_rd == 5'(r));
                dec[r] = wb_rd_en && (wb_rd == 5'(r)) && (cnt[r] != '0);
                if (inc[r] && !dec[r]) begin
                    cnt_nxt[r] = cnt[r] + CONE;
                end else if (dec[r] && !inc[r]) begin
                    cnt_nxt[r] = cnt[r] - CONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (flush) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt[r] <= '0;
                end
            end else begin
                cnt <= cnt_nxt;
            end
            if (wb_err && !flush) begin
                sb_err <= 1'b1;
            end
            if (id_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed self-checking bench for pipe_scoreboard.
// Expectations follow SB_WB_BYPASS_EN when the bench is built with it.
module tb_pipe_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_en;
    logic [4:0]  id_rs2;
    logic        id_rs2_en;
    logic [4:0]  id_rd;
    logic        id_rd_en;
    logic        exe_ready;
    logic        wb_rd_en;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        id_stall;
    logic        id_issue;
    logic        sb_err;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    pipe_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs1_en    (id_rs1_en),
        .id_rs2       (id_rs2),
        .id_rs2_en    (id_rs2_en),
        .id_rd        (id_rd),
        .id_rd_en     (id_rd_en),
        .exe_ready    (exe_ready),
        .wb_rd_en     (wb_rd_en),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .id_stall     (id_stall),
        .id_issue     (id_issue),
        .sb_err       (sb_err),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_rs1    = 5'd0;
        id_rs1_en = 1'b0;
        id_rs2    = 5'd0;
        id_rs2_en = 1'b0;
        id_rd     = 5'd0;
        id_rd_en  = 1'b0;
        exe_ready = 1'b1;
        wb_rd_en  = 1'b0;
        wb_rd     = 5'd0;
        flush     = 1'b0;
    endtask

    task automatic instr(input logic r1e, input logic [4:0] r1,
                         input logic r2e, input logic [4:0] r2,
                         input logic rde, input logic [4:0] rd);
        id_valid  = 1'b1;
        id_rs1_en = r1e;
        id_rs1    = r1;
        id_rs2_en = r2e;
        id_rs2    = r2;
        id_rd_en  = rde;
        id_rd     = rd;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        sync();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1);
        exe_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b0 || id_issue !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: stall=%b issue=%b want 0 0", id_stall, id_issue);
        end
        sync();
        idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_err !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: err=%b cyc=%0d want 0 0", sb_err, stall_cycles);
        end
        sync();
    endtask

    task automatic test_raw();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL raw_addi_issue: got %b want 1", id_issue);
        end
        sync();
        instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6);
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_add_stall: got %b want 1", id_stall);
        end
        sync();
        wb_rd_en = 1'b1;
        wb_rd    = 5'd5;
        @(negedge clk);
        checks++;
        if (id_issue !== BYP || id_stall !== !BYP) begin
            errors++;
            $display("FAIL raw_wb_cycle: issue=%b stall=%b want %b %b",
                     id_issue, id_stall, BYP, !BYP);
        end
        sync();
        wb_rd_en = 1'b0;
        if (BYP) begin
            id_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (id_issue !== !BYP) begin
            errors++;
            $display("FAIL raw_after_wb: issue=%b want %b", id_issue, !BYP);
        end
        sync();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL ld_issue: got %b want 1", id_issue);
        end
        sync();
        instr(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (id_stall !== 1'b1) begin
                errors++;
                $display("FAIL ld_use_stall%0d: got %b want 1", i, id_stall);
            end
            sync();
        end
        wb_rd_en = 1'b1;
        wb_rd    = 5'd7;
        @(negedge clk);
        checks++;
        if (id_stall !== !BYP) begin
            errors++;
            $display("FAIL ld_wb_stall: got %b want %b", id_stall, !BYP);
        end
        sync();
        wb_rd_en = 1'b0;
        if (BYP) begin
            id_valid = 1'b0;
        end
        sync();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cycles !== (BYP ? 32'd2 : 32'd3)) begin
            errors++;
            $display("FAIL ld_stall_cycles: got %0d want %0d",
                     stall_cycles, BYP ? 2 : 3);
        end
        sync();
    endtask

    task automatic test_waw();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (id_issue !== 1'b1) begin
                errors++;
                $display("FAIL waw_fill%0d: issue=%b want 1", i, id_issue);
            end
            sync();
        end
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_sat_stall: got %b want 1", id_stall);
        end
        sync();
        wb_rd_en = 1'b1;
        wb_rd    = 5'd9;
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_wb_still_full: stall=%b want 1", id_stall);
        end
        sync();
        // count is 2 here: issue and retire together must leave it at 2
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL waw_issue_wb: issue=%b want 1", id_issue);
        end
        sync();
        wb_rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL waw_third: issue=%b want 1", id_issue);
        end
        sync();
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_full_again: stall=%b want 1", id_stall);
        end
        sync();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        sync();
        sync();
        id_rd = 5'd4;
        sync();
        instr(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3);
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_stall: got %b want 1", id_stall);
        end
        flush    = 1'b1;
        wb_rd_en = 1'b1;
        wb_rd    = 5'd12;
        #1;
        checks++;
        if (id_issue !== 1'b0 || id_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: issue=%b stall=%b want 0 0", id_issue, id_stall);
        end
        sync();
        flush    = 1'b0;
        wb_rd_en = 1'b0;
        instr(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: issue=%b err=%b want 1 0", id_issue, sb_err);
        end
        sync();
        idle();
    endtask

    task automatic test_x0_err();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL x0_write: issue=%b want 1", id_issue);
        end
        sync();
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        wb_rd_en = 1'b1;
        wb_rd    = 5'd0;
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL x0_read: issue=%b want 1", id_issue);
        end
        sync();
        idle();
        wb_rd_en = 1'b1;
        wb_rd    = 5'd12;
        @(negedge clk);
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: got %b want 0", sb_err);
        end
        sync();
        idle();
        sync();
        sync();
        @(negedge clk);
        checks++;
        if (sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", sb_err);
        end
        sync();
        do_reset();
        @(negedge clk);
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b want 0", sb_err);
        end
        sync();
    endtask

    task automatic test_exe_ready();
        do_reset();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10);
        sync();
        instr(1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd11);
        exe_ready = 1'b0;
        wb_rd_en  = 1'b1;
        wb_rd     = 5'd12;
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1 || id_issue !== 1'b0) begin
            errors++;
            $display("FAIL busy_stall: stall=%b issue=%b want 1 0", id_stall, id_issue);
        end
        sync();
        wb_rd_en = 1'b0;
        exe_ready = 1'b1;
        instr(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_inc: issue=%b want 1", id_issue);
        end
        sync();
        instr(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b1 || sb_err !== 1'b1) begin
            errors++;
            $display("FAIL busy_keep10: stall=%b err=%b want 1 1", id_stall, sb_err);
        end
        sync();
        exe_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (id_stall !== 1'b0 || id_issue !== 1'b0 || stall_cycles !== 32'd2) begin
            errors++;
            $display("FAIL rst_mid: stall=%b issue=%b cyc=%0d want 0 0 2",
                     id_stall, id_issue, stall_cycles);
        end
        sync();
        rst = 1'b0;
        exe_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (id_issue !== 1'b1 || sb_err !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL rst_after: issue=%b err=%b cyc=%0d want 1 0 0",
                     id_issue, sb_err, stall_cycles);
        end
        sync();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        sync();
        test_reset();
        test_raw();
        test_load_use();
        test_waw();
        test_flush();
        test_x0_err();
        test_exe_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

endmodule
